// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the lab CPU control sequencer: opcodes, instruction
// classes, sequencer states and the control-word bundle.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD        = 5'b00000;
  localparam logic [4:0] OP_LDI       = 5'b00001;
  localparam logic [4:0] OP_ST        = 5'b00010;
  localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
  localparam logic [4:0] OP_ALU_LAST  = 5'b01011;
  localparam logic [4:0] OP_ALUI_LAST = 5'b01110;
  localparam logic [4:0] OP_MUL       = 5'b01111;
  localparam logic [4:0] OP_DIV       = 5'b10000;
  localparam logic [4:0] OP_NEG       = 5'b10001;
  localparam logic [4:0] OP_NOT       = 5'b10010;
  localparam logic [4:0] OP_BR        = 5'b10011;
  localparam logic [4:0] OP_JR        = 5'b10100;
  localparam logic [4:0] OP_IN        = 5'b10101;
  localparam logic [4:0] OP_OUT       = 5'b10110;
  localparam logic [4:0] OP_MFHI      = 5'b10111;
  localparam logic [4:0] OP_MFLO      = 5'b11000;
  localparam logic [4:0] OP_HALT      = 5'b11010;

  // Address and branch-target arithmetic always uses the adder.
  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_WAIT, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_ALUI, C_LD, C_LDI, C_ST, C_MULDIV, C_UNARY, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } op_class_t;

  typedef struct packed {
    logic       pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out, inport_out, c_out;
    logic       mar_in, mdr_in, ir_in, y_in, z_in, pc_in, hi_in, lo_in, outport_in, con_in, inc_pc;
    logic       read, write;
    logic       gra, grb, grc, r_in, r_out, ba_out;
    logic [4:0] alu_op;
  } ctrl_t;

  // Undefined opcodes fall into the nop class.
  function automatic op_class_t op_class(input logic [4:0] op);
    if (op >= OP_ALU_FIRST && op <= OP_ALU_LAST) return C_ALU;
    if (op > OP_ALU_LAST && op <= OP_ALUI_LAST)  return C_ALUI;
    case (op)
      OP_LD:          return C_LD;
      OP_LDI:         return C_LDI;
      OP_ST:          return C_ST;
      OP_MUL, OP_DIV: return C_MULDIV;
      OP_NEG, OP_NOT: return C_UNARY;
      OP_BR:          return C_BR;
      OP_JR:          return C_JR;
      OP_IN:          return C_IN;
      OP_OUT:         return C_OUT;
      OP_MFHI:        return C_MFHI;
      OP_MFLO:        return C_MFLO;
      OP_HALT:        return C_HALT;
      default:        return C_NOP;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_ctrl_word_decode.sv
// Combinational control-word decode from sequencer state, opcode and CON.
// Also flags the final step of an instruction and the halt step.
import cpu_ctrl_pkg::*;

module ctrl_word_decode (
  input  state_t     state,
  input  logic [4:0] opcode,
  input  logic       con,
  output ctrl_t      ctrl,
  output logic       last,
  output logic       halt
);

  op_class_t cls;
  assign cls = op_class(opcode);

  // Fetch steps are opcode-independent; execute steps decode by class.
  always_comb begin
    ctrl = '0;
    last = 1'b0;
    halt = 1'b0;
    case (state)
      S_T0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1; end
      S_T1: begin ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
      S_T2: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        case (cls)
          C_ALU, C_ALUI: begin
            case (state)
              S_T3: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
              S_T4: begin
                ctrl.z_in = 1'b1;
                if (cls == C_ALU) begin ctrl.grc = 1'b1; ctrl.r_out = 1'b1; end
                else ctrl.c_out = 1'b1;
              end
              S_T5: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; last = 1'b1; end
              default: ;
            endcase
          end
          C_LD, C_LDI, C_ST: begin
            case (state)
              S_T3: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
              S_T4: begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; end
              S_T5: begin
                ctrl.zlow_out = 1'b1;
                if (cls == C_LDI) begin ctrl.gra = 1'b1; ctrl.r_in = 1'b1; last = 1'b1; end
                else ctrl.mar_in = 1'b1;
              end
              S_T6: begin
                if (cls == C_LD) begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
                else if (cls == C_ST) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
              end
              S_T7: begin
                if (cls == C_LD) begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; last = 1'b1; end
                else if (cls == C_ST) begin ctrl.write = 1'b1; last = 1'b1; end
              end
              default: ;
            endcase
          end
          C_MULDIV: begin
            case (state)
              S_T3: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
              S_T4: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; end
              S_T5: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
              S_T6: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; last = 1'b1; end
              default: ;
            endcase
          end
          C_UNARY: begin
            case (state)
              S_T3: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; end
              S_T4: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; last = 1'b1; end
              default: ;
            endcase
          end
          C_BR: begin
            case (state)
              S_T3: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
              S_T4: begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
              S_T5: begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; end
              S_T6: begin ctrl.zlow_out = 1'b1; ctrl.pc_in = con; last = 1'b1; end
              default: ;
            endcase
          end
          default: begin
            // Remaining classes are single-step instructions executed in T3.
            if (state == S_T3) begin
              last = (cls != C_HALT);
              halt = (cls == C_HALT);
              case (cls)
                C_JR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
                C_IN:   begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                C_OUT:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
                C_MFHI: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                C_MFLO: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                default: ;
              endcase
            end
          end
        endcase
      end
      default: ;
    endcase
    // ALU op only matters when Z is loaded during execute; the fetch
    // increment in T0 goes through IncPC instead.
    if (ctrl.z_in && state != S_T0)
      ctrl.alu_op = (cls == C_ALU || cls == C_ALUI || cls == C_MULDIV || cls == C_UNARY)
                    ? opcode : ALU_ADD;
  end

endmodule

// File: rtl/control_unit.sv
// Control sequencer top: state register, memory handshake, stop/idle and halt.
import cpu_ctrl_pkg::*;

module control_unit (
  input  logic       clock,
  input  logic       clear,
  input  logic [4:0] opcode,
  input  logic       CON,
  input  logic       mem_ready,
  input  logic       stop,
  output logic       PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout,
  output logic       MARin, MDRin, IRin, Yin, Zin, PCin, HIin, LOin, OutPortin, CONin, IncPC,
  output logic       Read, Write,
  output logic       Gra, Grb, Grc, Rin, Rout, BAout,
  output logic [4:0] alu_op,
  output logic       run
);

  state_t state, nxt;
  ctrl_t  ctrl;
  logic   last, halt;

  ctrl_word_decode u_dec (
    .state  (state),
    .opcode (opcode),
    .con    (CON),
    .ctrl   (ctrl),
    .last   (last),
    .halt   (halt)
  );

  // Next step: memory steps stall on mem_ready, stop is honoured only at the
  // instruction boundary, HALT is sticky.
  always_comb begin
    nxt = state;
    case (state)
      S_RST:  nxt = S_T0;
      S_WAIT: nxt = stop ? S_WAIT : S_T0;
      S_HALT: nxt = S_HALT;
      default: begin
        if ((ctrl.read || ctrl.write) && !mem_ready) nxt = state;
        else if (halt)                               nxt = S_HALT;
        else if (last)                               nxt = stop ? S_WAIT : S_T0;
        else                                         nxt = state_t'(state + 4'd1);
      end
    endcase
  end

  // State register and registered run flag; clear wins over everything.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= S_RST;
      run   <= 1'b0;
    end else begin
      state <= nxt;
      run   <= (nxt != S_RST) && (nxt != S_HALT);
    end
  end

  assign PCout     = ctrl.pc_out;
  assign Zlowout   = ctrl.zlow_out;
  assign Zhighout  = ctrl.zhigh_out;
  assign MDRout    = ctrl.mdr_out;
  assign HIout     = ctrl.hi_out;
  assign LOout     = ctrl.lo_out;
  assign InPortout = ctrl.inport_out;
  assign Cout      = ctrl.c_out;
  assign MARin     = ctrl.mar_in;
  assign MDRin     = ctrl.mdr_in;
  assign IRin      = ctrl.ir_in;
  assign Yin       = ctrl.y_in;
  assign Zin       = ctrl.z_in;
  assign PCin      = ctrl.pc_in;
  assign HIin      = ctrl.hi_in;
  assign LOin      = ctrl.lo_in;
  assign OutPortin = ctrl.outport_in;
  assign CONin     = ctrl.con_in;
  assign IncPC     = ctrl.inc_pc;
  assign Read      = ctrl.read;
  assign Write     = ctrl.write;
  assign Gra       = ctrl.gra;
  assign Grb       = ctrl.grb;
  assign Grc       = ctrl.grc;
  assign Rin       = ctrl.r_in;
  assign Rout      = ctrl.r_out;
  assign BAout     = ctrl.ba_out;
  assign alu_op    = ctrl.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: every output is packed into one vector
// and compared against hand-built expected words step by step.
module tb_control_unit;

  logic       clock = 1'b0;
  logic       clear, CON, mem_ready, stop;
  logic [4:0] opcode;
  logic       PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout;
  logic       MARin, MDRin, IRin, Yin, Zin, PCin, HIin, LOin, OutPortin, CONin, IncPC;
  logic       Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run;
  logic [4:0] alu_op;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clock(clock), .clear(clear), .opcode(opcode), .CON(CON), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .HIin(HIin),
    .LOin(LOin), .OutPortin(OutPortin), .CONin(CONin), .IncPC(IncPC),
    .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .alu_op(alu_op), .run(run)
  );

  always #5 clock = ~clock;

  logic [32:0] obs;
  assign obs = {run, alu_op, BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, IncPC, CONin, OutPortin,
                LOin, HIin, PCin, Zin, Yin, IRin, MDRin, MARin, Cout, InPortout, LOout, HIout,
                MDRout, Zhighout, Zlowout, PCout};

  localparam logic [32:0] PCOUT = 33'h1 << 0,  ZLOW  = 33'h1 << 1,  ZHIGH = 33'h1 << 2,
                          MDROUT= 33'h1 << 3,  HIOUT = 33'h1 << 4,  LOOUT = 33'h1 << 5,
                          INPOUT= 33'h1 << 6,  COUT  = 33'h1 << 7,  MARIN = 33'h1 << 8,
                          MDRIN = 33'h1 << 9,  IRIN  = 33'h1 << 10, YIN   = 33'h1 << 11,
                          ZIN   = 33'h1 << 12, PCIN  = 33'h1 << 13, HIIN  = 33'h1 << 14,
                          LOIN  = 33'h1 << 15, OUTPIN= 33'h1 << 16, CONIN = 33'h1 << 17,
                          INCPC = 33'h1 << 18, READ  = 33'h1 << 19, WRITE = 33'h1 << 20,
                          GRA   = 33'h1 << 21, GRB   = 33'h1 << 22, GRC   = 33'h1 << 23,
                          RIN   = 33'h1 << 24, ROUT  = 33'h1 << 25, BAOUT = 33'h1 << 26,
                          RUN   = 33'h1 << 32;

  function automatic logic [32:0] aop(input logic [4:0] o);
    return {1'b0, o, 27'd0};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks T0..T2 starting at T0 and leaves the unit in T3.
  task automatic fetch(input logic [4:0] op, input string tag);
    opcode = op;
    chk({tag, "_t0"}, RUN | PCOUT | MARIN | INCPC | ZIN); step();
    chk({tag, "_t1"}, RUN | ZLOW | PCIN | READ | MDRIN); step();
    chk({tag, "_t2"}, RUN | MDROUT | IRIN);              step();
  endtask

  initial begin
    clear = 1'b0; CON = 1'b0; mem_ready = 1'b1; stop = 1'b0; opcode = 5'b0;

    // Reset held two cycles, then released.
    step(); chk("rst_c1", 33'h0);
    step(); chk("rst_c2", 33'h0);
    clear = 1'b1;
    step();

    // add R1,R2,R3
    fetch(5'b00011, "add");
    chk("add_t3", RUN | GRB | ROUT | YIN);                step();
    chk("add_t4", RUN | GRC | ROUT | ZIN | aop(5'b00011)); step();
    chk("add_t5", RUN | ZLOW | GRA | RIN);                step();

    // ld with three wait cycles in T6
    fetch(5'b00000, "ld");
    chk("ld_t3", RUN | GRB | BAOUT | YIN);       step();
    chk("ld_t4", RUN | COUT | ZIN | aop(5'b00011)); step();
    chk("ld_t5", RUN | ZLOW | MARIN);            step();
    chk("ld_t6_c1", RUN | READ | MDRIN);
    mem_ready = 1'b0;
    step(); chk("ld_t6_c2", RUN | READ | MDRIN);
    step(); chk("ld_t6_c3", RUN | READ | MDRIN);
    step(); chk("ld_t6_c4", RUN | READ | MDRIN);
    mem_ready = 1'b1;
    step(); chk("ld_t7", RUN | MDROUT | GRA | RIN);
    step();

    // br, condition false then true
    CON = 1'b0;
    fetch(5'b10011, "br0");
    chk("br0_t3", RUN | GRA | ROUT | CONIN);       step();
    chk("br0_t4", RUN | PCOUT | YIN);              step();
    chk("br0_t5", RUN | COUT | ZIN | aop(5'b00011)); step();
    chk("br0_t6", RUN | ZLOW);                     step();
    CON = 1'b1;
    fetch(5'b10011, "br1");
    chk("br1_t3", RUN | GRA | ROUT | CONIN);       step();
    chk("br1_t4", RUN | PCOUT | YIN);              step();
    chk("br1_t5", RUN | COUT | ZIN | aop(5'b00011)); step();
    chk("br1_t6", RUN | ZLOW | PCIN);              step();
    CON = 1'b0;

    // mul with stop raised mid-instruction
    fetch(5'b01111, "mul");
    chk("mul_t3", RUN | GRA | ROUT | YIN);
    step();
    chk("mul_t4", RUN | GRB | ROUT | ZIN | aop(5'b01111));
    stop = 1'b1;
    step(); chk("mul_t5", RUN | ZLOW | LOIN);
    step(); chk("mul_t6", RUN | ZHIGH | HIIN);
    step(); chk("idle_c1", RUN);
    step(); chk("idle_c2", RUN);
    stop = 1'b0;
    step();

    // st interrupted by clear in T5: Write must never appear
    fetch(5'b00010, "st");
    chk("st_t3", RUN | GRB | BAOUT | YIN);       step();
    chk("st_t4", RUN | COUT | ZIN | aop(5'b00011)); step();
    chk("st_t5", RUN | ZLOW | MARIN);
    clear = 1'b0;
    step(); chk("st_rst_c1", 33'h0);
    step(); chk("st_rst_c2", 33'h0);
    clear = 1'b1;
    step();

    // halt: sticky until reset
    fetch(5'b11010, "halt");
    chk("halt_t3", RUN);
    for (int i = 0; i < 20; i++) begin
      step(); chk("halt_idle", 33'h0);
    end
    clear = 1'b0;
    step(); chk("halt_rst", 33'h0);
    clear = 1'b1;
    step(); chk("halt_exit_t0", RUN | PCOUT | MARIN | INCPC | ZIN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
